transpose_stream_pingpong: RTL
==============================

// Module: transpose_stream_pingpong
// PURPOSE
//  Streaming NxN matrix transpose for the HE datapath. Accepts one matrix row per beat on a
//  valid/ready input and emits one row of the transposed matrix (or the original matrix, per-matrix
//  mode) per beat on a valid/ready output. Two ping-pong banks let matrix k+1 fill while matrix k
//  drains. Sits between the NTT row engines and the column-wise stage.
// PARAMETERS
//  DATA_WIDTH  64  bits per matrix element
//  N           8   matrix dimension (rows = cols = N); legal N >= 2
// PORTS
//  clk        in   1             clock, all state on posedge
//  rst        in   1             synchronous, active-high reset
//  in_valid   in   1             input row valid
//  in_ready   out  1             input row accepted when in_valid && in_ready
//  in_row     in   N*DATA_WIDTH  input row; element c at [c*DATA_WIDTH +: DATA_WIDTH]
//  in_mode    in   1             1 = transpose, 0 = pass-through; sampled on row 0 only
//  in_last    in   1             producer's end-of-matrix marker; checked, does not set framing
//  out_valid  out  1             output row valid
//  out_ready  in   1             output row consumed when out_valid && out_ready
//  out_row    out  N*DATA_WIDTH  output row, same element packing as in_row
//  out_last   out  1             high with the final row (row N-1) of each output matrix
//  out_mode   out  1             mode of the matrix now being drained
//  busy       out  1             any bank full, or partial matrix in the write bank
//  err_frame  out  1             sticky in_last framing error
// BEHAVIOUR
//  - State: two banks of NxN elements (not reset). Also wr_bank, rd_bank (1b each),
//    wr_row, rd_row (clog2 N), bank_full[1:0], bank_mode[1:0], err_frame.
//  - Reset values: wr_bank = rd_bank = 0, wr_row = rd_row = 0, bank_full = 0, err_frame = 0.
//    Outputs after reset: in_ready = 1, out_valid = 0, out_last = 0, out_row = 0, busy = 0.
//  - Write side: in_ready = !bank_full[wr_bank]. On accept, in_row is stored as row wr_row of bank[wr_bank].
//    On row 0, also latch bank_mode[wr_bank] <= in_mode.
//    If wr_row == N-1: set bank_full[wr_bank], toggle wr_bank, wr_row <= 0. Otherwise wr_row++.
//  - Framing check, per accepted row: (in_last && wr_row != N-1) or (!in_last && wr_row == N-1)
//    sets err_frame. It stays set until rst. Data flow continues under counter framing.
//  - Read side: out_valid = bank_full[rd_bank]; out_mode = bank_mode[rd_bank].
//    Transpose: out_row element e = bank[rd_bank][e][rd_row] (column rd_row).
//    Pass-through: out_row = bank[rd_bank][rd_row].
//    out_last = out_valid && rd_row == N-1. out_row is forced to 0 while out_valid = 0.
//  - On output handshake: if rd_row == N-1, clear bank_full[rd_bank], toggle rd_bank, rd_row <= 0.
//    Otherwise rd_row++. out_row/out_last hold stable while out_valid && !out_ready.
//  - Latency: row N-1 accepted at edge t means out_valid = 1 for output row 0 in the cycle after t.
//  - Throughput: with out_ready held 1, sustained 1 row/cycle in and out. in_ready never drops.
//  - Simultaneous set/clear of bank_full hits different banks (set needs !full, clear needs full),
//    so both take effect in the same cycle. A bank cleared at edge t is writable (in_ready = 1)
//    in the cycle after t.
//  - Both banks full: in_ready = 0 until the drain of rd_bank completes.
//  - Reset mid-operation: any partial or pending matrix is discarded. No output beats after rst.
//  - busy = |bank_full || wr_row != 0.
// TESTING (N=4, DATA_WIDTH=8, element(r,c) = 16r+c unless stated)
//  1. One matrix, mode=1, out_ready=1 -> out rows {00,10,20,30},{01,11,21,31},{02,..},{03,13,23,33}
//     (element 0 first). out_valid rises 1 cycle after the 4th accept. out_last only on the 4th row.
//  2. One matrix, mode=0 -> out rows equal in rows in order. out_mode = 0 throughout.
//  3. Three matrices back-to-back (in_valid = 1 for 12 cycles), modes 1,0,1, out_ready = 1
//     -> in_ready stays 1. 12 contiguous out beats. out_mode follows 1,0,1.
//  4. out_ready = 0, push 8 rows -> in_ready = 0 after the 8th accept. Raise out_ready
//     -> in_ready returns 1 the cycle after the 4th out beat. Data is correct.
//  5. in_last asserted on row 2, deasserted on row 3 -> err_frame = 1 and sticky.
//     Still exactly 4 correct out rows.
//  6. rst pulsed after 2 accepted rows -> in_ready = 1, out_valid = 0, busy = 0, err_frame = 0.
//     The next 4 rows form a fresh, correct matrix.

Source files
------------

// File: rtl/transpose_stream_pingpong.sv
// Streaming NxN matrix transpose with ping-pong banks.
// One matrix row is accepted per input beat. Each completed matrix is drained one row per
// output beat, either transposed or passed through, as chosen by the mode sampled on row 0.
// Matrix k+1 fills one bank while matrix k drains from the other.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        input row handshake
//   in_row                   input row, element c at [c*DATA_WIDTH +: DATA_WIDTH]
//   in_mode                  1 = transpose, 0 = pass-through (sampled on row 0)
//   in_last                  producer end-of-matrix marker (checked only)
//   out_valid/out_ready      output row handshake
//   out_row                  output row, same packing as in_row
//   out_last                 final row of each output matrix
//   out_mode                 mode of the matrix being drained
//   busy                     any bank full or a partial matrix in the write bank
//   err_frame                sticky in_last framing error
module transpose_stream_pingpong #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned N          = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N*DATA_WIDTH-1:0] in_row,
    input  logic                    in_mode,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [N*DATA_WIDTH-1:0] out_row,
    output logic                    out_last,
    output logic                    out_mode,
    output logic                    busy,
    output logic                    err_frame
);

    localparam int unsigned RW = $clog2(N);
    localparam logic [RW-1:0] LAST_ROW = RW'(N - 1);

    // Matrix storage: mem_q[bank][row][col]; holds data only, never reset.
    logic [DATA_WIDTH-1:0] mem_q [2][N][N];

    logic          wr_bank_q, wr_bank_d;
    logic          rd_bank_q, rd_bank_d;
    logic [RW-1:0] wr_row_q,  wr_row_d;
    logic [RW-1:0] rd_row_q,  rd_row_d;
    logic [1:0]    bank_full_q, bank_full_d;
    logic [1:0]    bank_mode_q, bank_mode_d;
    logic          err_frame_q, err_frame_d;

    logic in_fire;
    logic out_fire;
    logic wr_at_last;
    logic rd_at_last;

    assign in_ready   = !bank_full_q[wr_bank_q];
    assign out_valid  = bank_full_q[rd_bank_q];
    assign out_mode   = bank_mode_q[rd_bank_q];
    assign in_fire    = in_valid && in_ready;
    assign out_fire   = out_valid && out_ready;
    assign wr_at_last = (wr_row_q == LAST_ROW);
    assign rd_at_last = (rd_row_q == LAST_ROW);
    assign out_last   = out_valid && rd_at_last;
    assign busy       = (|bank_full_q) || (wr_row_q != '0);
    assign err_frame  = err_frame_q;

    // Row write into the current write bank.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            for (int c = 0; c < N; c++) begin
                mem_q[wr_bank_q][wr_row_q][c] <= in_row[c*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Output row select: column rd_row when transposing, row rd_row otherwise; zero when idle.
    always_comb begin
        out_row = '0;
        if (out_valid) begin
            for (int e = 0; e < N; e++) begin
                out_row[e*DATA_WIDTH +: DATA_WIDTH] = out_mode ? mem_q[rd_bank_q][e][rd_row_q]
                                                               : mem_q[rd_bank_q][rd_row_q][e];
            end
        end
    end

    // Control next-state. Set and clear of bank_full always target different banks.
    always_comb begin
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        wr_row_d    = wr_row_q;
        rd_row_d    = rd_row_q;
        bank_full_d = bank_full_q;
        bank_mode_d = bank_mode_q;
        err_frame_d = err_frame_q;

        if (in_fire) begin
            if (wr_row_q == '0) begin
                bank_mode_d[wr_bank_q] = in_mode;
            end
            if (in_last != wr_at_last) begin
                err_frame_d = 1'b1;
            end
            if (wr_at_last) begin
                bank_full_d[wr_bank_q] = 1'b1;
                wr_bank_d              = !wr_bank_q;
                wr_row_d               = '0;
            end else begin
                wr_row_d = wr_row_q + RW'(1);
            end
        end

        if (out_fire) begin
            if (rd_at_last) begin
                bank_full_d[rd_bank_q] = 1'b0;
                rd_bank_d              = !rd_bank_q;
                rd_row_d               = '0;
            end else begin
                rd_row_d = rd_row_q + RW'(1);
            end
        end
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            wr_row_q    <= '0;
            rd_row_q    <= '0;
            bank_full_q <= 2'b00;
            bank_mode_q <= 2'b00;
            err_frame_q <= 1'b0;
        end else begin
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            wr_row_q    <= wr_row_d;
            rd_row_q    <= rd_row_d;
            bank_full_q <= bank_full_d;
            bank_mode_q <= bank_mode_d;
            err_frame_q <= err_frame_d;
        end
    end

endmodule
